// File: rtl/point_addsub_seq.sv
// Sequential affine point adder/subtractor over GF(p) for short-Weierstrass curves.
// One shared MSB-first modular multiplier serves every field product, including the inverse.

`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module point_addsub_seq #(
    parameter int unsigned WIDTH = `DATAWIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] Px,
    input  logic [WIDTH-1:0] Py,
    input  logic             P_inf,
    input  logic [WIDTH-1:0] Qx,
    input  logic [WIDTH-1:0] Qy,
    input  logic             Q_inf,
    input  logic [WIDTH-1:0] mod_p,
    input  logic [WIDTH-1:0] coef_a,
    output logic [WIDTH-1:0] Rx_out,
    output logic [WIDTH-1:0] Ry_out,
    output logic             R_inf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StCheck, StNum, StInv, StLambda, StX3, StY3, StDone
    } state_e;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return d[WIDTH-1:0];
    endfunction

    // One double-and-add step: 2*acc (+ a) reduced back into [0, m).
    function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic             bit_in,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        if (bit_in) begin
            t = t + {1'b0, a};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end
        return t[WIDTH-1:0];
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
    logic [WIDTH-1:0] p_q, p_d, a_q, a_d;
    logic             pinf_q, pinf_d, qinf_q, qinf_d, dbl_q, dbl_d;
    logic [WIDTH-1:0] num_q, num_d, den_q, den_d, inv_q, inv_d;
    logic [WIDTH-1:0] lam_q, lam_d, x3_q, x3_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
    logic             rinf_q, rinf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d, ebit_q, ebit_d;
    logic             phase_q, phase_d;

    logic [WIDTH-1:0] mul_a, mul_b, mul_res, acc_in, exp_p;
    logic             mul_busy, mul_last, mul_first;

    assign mul_busy  = (state_q == StNum) || (state_q == StInv) || (state_q == StLambda) ||
                       (state_q == StX3) || (state_q == StY3);
    assign mul_first = (cnt_q == CW'(WIDTH - 1));
    assign mul_last  = (cnt_q == '0);
    assign acc_in    = mul_first ? '0 : acc_q;
    assign mul_res   = mul_step(acc_in, mul_a, mul_b[cnt_q], p_q);
    assign exp_p     = p_q - WIDTH'(2);

    always_comb begin
        mul_a = px_q;
        mul_b = px_q;
        case (state_q)
            StInv: begin
                mul_a = inv_q;
                mul_b = phase_q ? den_q : inv_q;
            end
            StLambda: begin
                mul_a = num_q;
                mul_b = inv_q;
            end
            StX3: begin
                mul_a = lam_q;
                mul_b = lam_q;
            end
            StY3: begin
                mul_a = lam_q;
                mul_b = mod_sub(px_q, x3_q, p_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        qx_d      = qx_q;
        qy_d      = qy_q;
        p_d       = p_q;
        a_d       = a_q;
        pinf_d    = pinf_q;
        qinf_d    = qinf_q;
        dbl_d     = dbl_q;
        num_d     = num_q;
        den_d     = den_q;
        inv_d     = inv_q;
        lam_d     = lam_q;
        x3_d      = x3_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        rinf_d    = rinf_q;
        acc_d     = mul_res;
        cnt_d     = (mul_busy && !mul_last) ? cnt_q - CW'(1) : CW'(WIDTH - 1);
        ebit_d    = ebit_q;
        phase_d   = phase_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    px_d    = Px;
                    py_d    = Py;
                    qx_d    = Qx;
                    // Subtraction is addition of -Q; negate y once at capture.
                    qy_d    = (op_sub && (Qy != '0)) ? mod_p - Qy : Qy;
                    pinf_d  = P_inf;
                    qinf_d  = Q_inf;
                    p_d     = mod_p;
                    a_d     = coef_a;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (pinf_q) begin
                    rx_d    = qinf_q ? '0 : qx_q;
                    ry_d    = qinf_q ? '0 : qy_q;
                    rinf_d  = qinf_q;
                    state_d = StDone;
                end else if (qinf_q) begin
                    rx_d    = px_q;
                    ry_d    = py_q;
                    rinf_d  = 1'b0;
                    state_d = StDone;
                end else if ((px_q == qx_q) && (mod_add(py_q, qy_q, p_q) == '0)) begin
                    rx_d    = '0;
                    ry_d    = '0;
                    rinf_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    dbl_d   = (px_q == qx_q) && (py_q == qy_q);
                    state_d = StNum;
                end
            end
            StNum: begin
                // The add path runs the Px^2 product too, keeping both paths equal in length.
                if (mul_last) begin
                    if (dbl_q) begin
                        num_d = mod_add(mod_add(mod_add(mul_res, mul_res, p_q), mul_res, p_q),
                                        a_q, p_q);
                        den_d = mod_add(py_q, py_q, p_q);
                    end else begin
                        num_d = mod_sub(qy_q, py_q, p_q);
                        den_d = mod_sub(qx_q, px_q, p_q);
                    end
                    inv_d   = WIDTH'(1);
                    ebit_d  = CW'(WIDTH - 1);
                    phase_d = 1'b0;
                    state_d = StInv;
                end
            end
            StInv: begin
                if (mul_last) begin
                    if (!phase_q) begin
                        inv_d   = mul_res;
                        phase_d = 1'b1;
                    end else begin
                        if (exp_p[ebit_q]) inv_d = mul_res;
                        phase_d = 1'b0;
                        if (ebit_q == '0) state_d = StLambda;
                        else              ebit_d  = ebit_q - CW'(1);
                    end
                end
            end
            StLambda: begin
                if (mul_last) begin
                    lam_d   = mul_res;
                    state_d = StX3;
                end
            end
            StX3: begin
                if (mul_last) begin
                    x3_d    = mod_sub(mod_sub(mul_res, px_q, p_q), qx_q, p_q);
                    state_d = StY3;
                end
            end
            StY3: begin
                if (mul_last) begin
                    rx_d    = x3_q;
                    ry_d    = mod_sub(mul_res, py_q, p_q);
                    rinf_d  = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            px_q    <= '0;
            py_q    <= '0;
            qx_q    <= '0;
            qy_q    <= '0;
            p_q     <= '0;
            a_q     <= '0;
            pinf_q  <= 1'b0;
            qinf_q  <= 1'b0;
            dbl_q   <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
            inv_q   <= '0;
            lam_q   <= '0;
            x3_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            rinf_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            ebit_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            p_q     <= p_d;
            a_q     <= a_d;
            pinf_q  <= pinf_d;
            qinf_q  <= qinf_d;
            dbl_q   <= dbl_d;
            num_q   <= num_d;
            den_q   <= den_d;
            inv_q   <= inv_d;
            lam_q   <= lam_d;
            x3_q    <= x3_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rinf_q  <= rinf_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ebit_q  <= ebit_d;
            phase_q <= phase_d;
        end
    end

    assign Rx_out = rx_q;
    assign Ry_out = ry_q;
    assign R_inf  = rinf_q;

endmodule

// File: tb/tb_point_addsub_seq.sv
// Bench for point_addsub_seq at WIDTH = 5: directed curve cases, handshake, reset and
// randomized operations on random small curves checked against a plain-arithmetic model.

module tb_point_addsub_seq;

    localparam int W   = 5;
    localparam int LAT = (2 * W + 4) * W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] Px = '0, Py = '0, Qx = '0, Qy = '0, mod_p = 5'd17, coef_a = 5'd2;
    logic         P_inf = 1'b0, Q_inf = 1'b0;
    logic [W-1:0] Rx_out, Ry_out;
    logic         R_inf, out_valid;
    logic         out_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    point_addsub_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .Px(Px), .Py(Py), .P_inf(P_inf), .Qx(Qx), .Qy(Qy), .Q_inf(Q_inf), .mod_p(mod_p),
        .coef_a(coef_a), .Rx_out(Rx_out), .Ry_out(Ry_out), .R_inf(R_inf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        bit sub; int px; int py; bit pinf; int qx; int qy; bit qinf;
        int rx; int ry; bit rinf; int lat;
    } dcase_t;

    function automatic int inv_mod(int x, int p);
        for (int i = 1; i < p; i++) if ((x * i) % p == 1) return i;
        return 0;
    endfunction

    // Textbook affine group law with negation of Q for subtraction.
    task automatic ref_point(input int p, input int a, input bit sub, input int px, input int py,
                             input bit pinf, input int qx, input int qy, input bit qinf,
                             output int rx, output int ry, output bit rinf, output int lat);
        int qy2, lam, x3;
        qy2 = sub ? (p - qy) % p : qy;
        lat = 2;
        rx = 0; ry = 0; rinf = 0;
        if (pinf) begin
            rinf = qinf;
            if (!qinf) begin rx = qx; ry = qy2; end
        end else if (qinf) begin
            rx = px; ry = py;
        end else if (px == qx && (py + qy2) % p == 0) begin
            rinf = 1;
        end else begin
            if (px == qx) lam = ((3 * px * px + a) % p) * inv_mod((2 * py) % p, p) % p;
            else lam = ((qy2 - py + p) % p) * inv_mod((qx - px + p) % p, p) % p;
            x3 = ((lam * lam) % p + 2 * p - px - qx) % p;
            rx = x3;
            ry = ((lam * ((px - x3 + p) % p)) % p + p - py) % p;
            lat = LAT;
        end
    endtask

    task automatic drive_op(input bit sub, input int px, input int py, input bit pinf,
                            input int qx, input int qy, input bit qinf, input int p, input int a);
        op_sub = sub; Px = W'(px); Py = W'(py); P_inf = pinf;
        Qx = W'(qx); Qy = W'(qy); Q_inf = qinf; mod_p = W'(p); coef_a = W'(a);
        in_valid = 1'b1;
    endtask

    task automatic scramble;
        op_sub = 1'($urandom); Px = W'($urandom); Py = W'($urandom); P_inf = 1'($urandom);
        Qx = W'($urandom); Qy = W'($urandom); Q_inf = 1'($urandom);
        mod_p = W'($urandom); coef_a = W'($urandom);
    endtask

    // Returns at the negedge of the first out_valid cycle; lat = -1 when the bound expires.
    task automatic do_op(input bit sub, input int px, input int py, input bit pinf,
                         input int qx, input int qy, input bit qinf, input int p, input int a,
                         output int rx, output int ry, output bit rinf, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin @(negedge clk); guard++; end
        drive_op(sub, px, py, pinf, qx, qy, qinf, p, a);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 1000) begin @(negedge clk); lat++; end
        if (!out_valid) lat = -1;
        rx = int'(Rx_out); ry = int'(Ry_out); rinf = R_inf;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_op(0, 5, 1, 0, 5, 1, 0, 17, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (Rx_out !== '0 || Ry_out !== '0 || R_inf !== 1'b0)
            $display("FAIL reset_outputs got (%0d,%0d,%b) want (0,0,0)", Rx_out, Ry_out, R_inf);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_no_capture got ready=%b valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_directed;
        dcase_t dt[7];
        int rx, ry, lat;
        bit rinf;
        dt[0] = '{0, 5, 1, 0, 5, 1, 0, 6, 3, 0, LAT};
        dt[1] = '{0, 6, 3, 0, 5, 1, 0, 10, 6, 0, LAT};
        dt[2] = '{1, 10, 6, 0, 5, 1, 0, 6, 3, 0, LAT};
        dt[3] = '{1, 5, 1, 0, 5, 1, 0, 0, 0, 1, 2};
        dt[4] = '{0, 7, 6, 0, 7, 11, 0, 0, 0, 1, 2};
        dt[5] = '{1, 23, 9, 1, 5, 1, 0, 5, 16, 0, 2};
        dt[6] = '{0, 9, 16, 0, 30, 4, 1, 9, 16, 0, 2};
        for (int i = 0; i < 7; i++) begin
            do_op(dt[i].sub, dt[i].px, dt[i].py, dt[i].pinf, dt[i].qx, dt[i].qy, dt[i].qinf,
                  17, 2, rx, ry, rinf, lat);
            n_checks++;
            if (rx !== dt[i].rx || ry !== dt[i].ry || rinf !== dt[i].rinf)
                $display("FAIL directed_%0d_result got (%0d,%0d,%b) want (%0d,%0d,%b)", i, rx,
                         ry, rinf, dt[i].rx, dt[i].ry, dt[i].rinf);
            else n_pass++;
            n_checks++;
            if (lat !== dt[i].lat)
                $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, dt[i].lat);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL directed_%0d_release got valid=%b ready=%b want 0/1", i,
                         out_valid, in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int rx, ry, lat;
        bit rinf;
        out_ready = 1'b0;
        do_op(0, 5, 1, 0, 5, 1, 0, 17, 2, rx, ry, rinf, lat);
        n_checks++;
        if (rx !== 6 || ry !== 3 || rinf !== 1'b0 || lat !== LAT)
            $display("FAIL hold_result got (%0d,%0d,%b) lat %0d want (6,3,0) lat %0d", rx, ry,
                     rinf, lat, LAT);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Rx_out !== 5'd6 || Ry_out !== 5'd3 ||
                R_inf !== 1'b0)
                $display("FAIL hold_cycle_%0d got v=%b r=%b (%0d,%0d,%b) want 1/0 (6,3,0)", i,
                         out_valid, in_ready, Rx_out, Ry_out, R_inf);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL hold_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat, busy_bad;
        @(negedge clk);
        drive_op(0, 6, 3, 0, 5, 1, 0, 17, 2);
        @(posedge clk);
        @(negedge clk);
        drive_op(1, 10, 6, 0, 5, 1, 0, 17, 2);
        lat = 1; busy_bad = 0;
        while (!out_valid && lat < 1000) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(negedge clk); lat++;
        end
        n_checks++;
        if (busy_bad != 0) $display("FAIL b2b_busy_ready got %0d ready cycles want 0", busy_bad);
        else n_pass++;
        n_checks++;
        if (Rx_out !== 5'd10 || Ry_out !== 5'd6 || R_inf !== 1'b0 || lat != LAT)
            $display("FAIL b2b_first got (%0d,%0d,%b) lat %0d want (10,6,0) lat %0d", Rx_out,
                     Ry_out, R_inf, lat, LAT);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL b2b_idle got ready=%b valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 1000) begin @(negedge clk); lat++; end
        n_checks++;
        if (Rx_out !== 5'd6 || Ry_out !== 5'd3 || R_inf !== 1'b0 || lat != LAT)
            $display("FAIL b2b_second got (%0d,%0d,%b) lat %0d want (6,3,0) lat %0d", Rx_out,
                     Ry_out, R_inf, lat, LAT);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int rx, ry, lat, seen;
        bit rinf;
        @(negedge clk);
        drive_op(0, 5, 1, 0, 5, 1, 0, 17, 2);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Rx_out !== '0 || R_inf !== 1'b0)
            $display("FAIL midreset_state got ready=%b valid=%b rx=%0d inf=%b want 1/0/0/0",
                     in_ready, out_valid, Rx_out, R_inf);
        else n_pass++;
        seen = 0;
        repeat (100) begin @(negedge clk); if (out_valid) seen++; end
        n_checks++;
        if (seen != 0) $display("FAIL midreset_no_output got %0d valid cycles want 0", seen);
        else n_pass++;
        do_op(0, 6, 3, 0, 5, 1, 0, 17, 2, rx, ry, rinf, lat);
        n_checks++;
        if (rx !== 10 || ry !== 6 || rinf !== 1'b0 || lat !== LAT)
            $display("FAIL midreset_next got (%0d,%0d,%b) lat %0d want (10,6,0) lat %0d", rx, ry,
                     rinf, lat, LAT);
        else n_pass++;
    endtask

    task automatic test_random;
        int primes[9] = '{5, 7, 11, 13, 17, 19, 23, 29, 31};
        int xs[$], ys[$];
        int p, a, b, i, j, px, py, qx, qy, rx, ry, lat, erx, ery, elat, mode;
        bit sub, pinf, qinf, rinf, erinf;
        for (int n = 0; n < 40; n++) begin
            do begin
                p = primes[$urandom_range(8)];
                a = $urandom_range(p - 1);
                b = $urandom_range(p - 1);
                xs.delete(); ys.delete();
                for (int x = 0; x < p; x++)
                    for (int y = 0; y < p; y++)
                        if ((y * y) % p == (x * x * x + a * x + b) % p) begin
                            xs.push_back(x); ys.push_back(y);
                        end
            end while (xs.size() == 0);
            i = $urandom_range(xs.size() - 1);
            px = xs[i]; py = ys[i];
            mode = $urandom_range(7);
            if (mode == 0) begin qx = px; qy = py; end
            else if (mode == 1) begin qx = px; qy = (p - py) % p; end
            else begin j = $urandom_range(xs.size() - 1); qx = xs[j]; qy = ys[j]; end
            sub  = 1'($urandom);
            pinf = ($urandom_range(7) == 0);
            qinf = ($urandom_range(7) == 0);
            if (pinf) begin px = $urandom_range(31); py = $urandom_range(31); end
            ref_point(p, a, sub, px, py, pinf, qx, qy, qinf, erx, ery, erinf, elat);
            do_op(sub, px, py, pinf, qx, qy, qinf, p, a, rx, ry, rinf, lat);
            n_checks++;
            if (rx !== erx || ry !== ery || rinf !== erinf)
                $display("FAIL random_%0d_result p=%0d a=%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                         n, p, a, rx, ry, rinf, erx, ery, erinf);
            else n_pass++;
            n_checks++;
            if (lat !== elat) $display("FAIL random_%0d_latency got %0d want %0d", n, lat, elat);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
